// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD,
      LEN_HI,
      LEN_LO,
      WAIT
   } pad_state_e;

   localparam int          SHA256_BLOCK_WORDS = 16;
   localparam logic [3:0]  SHA256_LEN_SLOT_HI = 4'd14;
   localparam logic [3:0]  SHA256_LEN_SLOT_LO = 4'd15;
   // Last slot that can still carry marker/zero fill when the length fits in this block
   localparam logic [3:0]  SHA256_PAD_END     = SHA256_LEN_SLOT_HI - 4'd1;
   localparam logic [31:0] SHA256_PAD_MARKER  = 32'h8000_0000;

endpackage

// File: rtl/sha256_pad_marker.sv
// Builds the final message word: keeps the valid leading bytes, inserts 0x80, zeroes the rest.
import sha256_pkg::*;

module sha256_pad_marker (
   input  logic [31:0] in_data,
   input  logic [2:0]  in_nbytes,
   output logic [31:0] marked
);

   always_comb begin
      marked = in_data;
      case (in_nbytes)
         3'd0:    marked = SHA256_PAD_MARKER;
         3'd1:    marked = {in_data[31:24], 8'h80, 16'h0000};
         3'd2:    marked = {in_data[31:16], 8'h80, 8'h00};
         3'd3:    marked = {in_data[31:8], 8'h80};
         default: marked = in_data;
      endcase
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams words into the 16-word scheduler store with FIPS 180-4 padding.
// Optional block/message counters are compiled in with SHA256_PAD_STATS_EN.
//
// state  | meaning
// IDLE   | no message in flight, waiting for the first word
// LOAD   | accepting message words into the current block
// PAD    | writing the pending marker or zero fill
// LEN_HI | writing bit-length [63:32] at slot 14
// LEN_LO | writing bit-length [31:0] at slot 15
// WAIT   | block complete, holding blk_valid until blk_done
import sha256_pkg::*;

module sha256_msg_padder #(
   parameter int LEN_W = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic [2:0]  in_nbytes,
   output logic [31:0] word_out,
   output logic [3:0]  word_addr,
   output logic        word_we,
   output logic        blk_valid,
   output logic        blk_last,
   input  logic        blk_done,
   output logic        busy
`ifdef SHA256_PAD_STATS_EN
   ,
   output logic [31:0] blk_count,
   output logic [31:0] msg_count
`endif
);

   pad_state_e state, state_n;
   logic [$clog2(SHA256_BLOCK_WORDS)-1:0] widx, widx_n;
   logic [LEN_W-1:0] bitlen, bitlen_n;
   logic        mk_pend, mk_pend_n;
   logic        resume_pad, resume_pad_n;
   logic        last_flag, last_flag_n;
   logic        in_ready_n, word_we_n, blk_valid_n, blk_last_n, busy_n;
   logic [31:0] word_out_n;
   logic [3:0]  word_addr_n;
   logic [31:0] marked;
   logic [63:0] len64;
   logic        accept, ack;

   sha256_pad_marker u_marker (
      .in_data   (in_data),
      .in_nbytes (in_nbytes),
      .marked    (marked)
   );

   assign accept = in_valid && in_ready;
   assign ack    = blk_valid && blk_done;

   always_comb begin
      state_n      = state;
      widx_n       = widx;
      bitlen_n     = bitlen;
      mk_pend_n    = mk_pend;
      resume_pad_n = resume_pad;
      last_flag_n  = last_flag;
      word_we_n    = 1'b0;
      word_addr_n  = word_addr;
      word_out_n   = word_out;
      blk_valid_n  = 1'b0;
      blk_last_n   = 1'b0;
      len64        = '0;
      len64[LEN_W-1:0] = bitlen;

      case (state)
         IDLE, LOAD: begin
            if (accept) begin
               word_we_n   = 1'b1;
               word_addr_n = widx;
               widx_n      = widx + 4'd1;
               if (!in_last) begin
                  word_out_n   = in_data;
                  bitlen_n     = bitlen + LEN_W'(32);
                  resume_pad_n = 1'b0;
                  last_flag_n  = 1'b0;
                  state_n      = (widx == SHA256_LEN_SLOT_LO) ? WAIT : LOAD;
               end else begin
                  bitlen_n = bitlen + LEN_W'({in_nbytes, 3'b000});
                  if (in_nbytes == 3'd4) begin
                     // Full final word: the marker goes into the following slot
                     word_out_n = in_data;
                     mk_pend_n  = 1'b1;
                     if (widx == SHA256_LEN_SLOT_LO) begin
                        state_n      = WAIT;
                        resume_pad_n = 1'b1;
                        last_flag_n  = 1'b0;
                     end else begin
                        state_n = PAD;
                     end
                  end else begin
                     word_out_n = marked;
                     mk_pend_n  = 1'b0;
                     if (widx == SHA256_PAD_END) begin
                        state_n = LEN_HI;
                     end else if (widx == SHA256_LEN_SLOT_LO) begin
                        state_n      = WAIT;
                        resume_pad_n = 1'b1;
                        last_flag_n  = 1'b0;
                     end else begin
                        state_n = PAD;
                     end
                  end
               end
            end
         end
         PAD: begin
            word_we_n   = 1'b1;
            word_addr_n = widx;
            word_out_n  = mk_pend ? SHA256_PAD_MARKER : 32'h0;
            mk_pend_n   = 1'b0;
            widx_n      = widx + 4'd1;
            // Slots 14/15 are only reached here when the marker pushed the length into an extra block
            if (widx == SHA256_PAD_END) begin
               state_n = LEN_HI;
            end else if (widx == SHA256_LEN_SLOT_LO) begin
               state_n      = WAIT;
               resume_pad_n = 1'b1;
               last_flag_n  = 1'b0;
            end
         end
         LEN_HI: begin
            word_we_n   = 1'b1;
            word_addr_n = widx;
            word_out_n  = len64[63:32];
            widx_n      = widx + 4'd1;
            state_n     = LEN_LO;
         end
         LEN_LO: begin
            word_we_n   = 1'b1;
            word_addr_n = widx;
            word_out_n  = len64[31:0];
            widx_n      = '0;
            last_flag_n = 1'b1;
            state_n     = WAIT;
         end
         WAIT: begin
            blk_valid_n = !ack;
            blk_last_n  = last_flag && !ack;
            if (ack) begin
               if (last_flag) begin
                  state_n     = IDLE;
                  bitlen_n    = '0;
                  widx_n      = '0;
                  last_flag_n = 1'b0;
               end else begin
                  state_n = resume_pad ? PAD : LOAD;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      in_ready_n = (state_n == IDLE) || (state_n == LOAD);
      busy_n     = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         widx       <= '0;
         bitlen     <= '0;
         mk_pend    <= 1'b0;
         resume_pad <= 1'b0;
         last_flag  <= 1'b0;
         in_ready   <= 1'b1;
         word_out   <= '0;
         word_addr  <= '0;
         word_we    <= 1'b0;
         blk_valid  <= 1'b0;
         blk_last   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         widx       <= widx_n;
         bitlen     <= bitlen_n;
         mk_pend    <= mk_pend_n;
         resume_pad <= resume_pad_n;
         last_flag  <= last_flag_n;
         in_ready   <= in_ready_n;
         word_out   <= word_out_n;
         word_addr  <= word_addr_n;
         word_we    <= word_we_n;
         blk_valid  <= blk_valid_n;
         blk_last   <= blk_last_n;
         busy       <= busy_n;
      end
   end

`ifdef SHA256_PAD_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blk_count <= '0;
         msg_count <= '0;
      end else if (ack) begin
         blk_count <= blk_count + 32'd1;
         if (last_flag) msg_count <= msg_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Upstream stage of the SHA-256 message scheduler. It accepts a raw message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit bit-length. It writes each 512-bit block into the scheduler's 16-word store one word per cycle, then holds until the core reports the block consumed. It tracks block boundaries and the running bit-length across multi-block messages.

Parameters:
LEN_W, 64, width of the internal bit-length counter (2..64); counter bits above LEN_W-1 are emitted as zero in the length field.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  padder can accept in_data this cycle
in_data  input  32  message word, byte 0 in [31:24]
in_last  input  1  final word of message
in_nbytes  input  3  valid bytes in in_data (0..4); must be 4 when in_last=0
word_out  output  32  word written to the scheduler store
word_addr  output  4  store address 0..15
word_we  output  1  write strobe, one word per cycle
blk_valid  output  1  16 words written, block ready for the core
blk_last  output  1  qualifies blk_valid: final block of the message
blk_done  input  1  core finished the block; store may be overwritten
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE, widx=0, bitlen=0, all outputs 0 except in_ready=1.
- Clocking: clk and reset_n as decided, asynchronous active-low. All outputs are registered.
- Transfer rule: a word transfers when in_valid && in_ready. Each accepted word produces word_we=1 on the next cycle at word_addr=widx; widx then increments.
- in_ready is high only in IDLE or LOAD while widx<=15.
- IDLE: the first accepted word moves the FSM to LOAD.
- LOAD, non-last word: writes in_data and adds 32 to bitlen. When widx wraps from 15 the FSM moves to WAIT with blk_last=0.
- LOAD, last word with n=in_nbytes: adds 8*n to bitlen.
  - n=1..3: writes the data bytes, 0x80 at byte n, lower bytes 0.
  - n=4: writes the data word, then writes 0x80000000 in the next write slot.
  - n=0: writes 0x80000000 at widx; no data is written.
  - The marker is placed with address wrap: if it falls after slot 15, the FSM enters WAIT and places the marker at slot 0 of the next block.
- PAD: writes zero words up to and including slot 13, then LEN_HI (slot 14 = bitlen[63:32]) and LEN_LO (slot 15 = bitlen[31:0]), then WAIT with blk_last=1.
- Extra block: if the marker occupies slot 14 or 15, the remaining slots through 15 are zero-filled. The FSM then enters WAIT with blk_last=0, and after blk_done the next block writes zeros at 0..13 followed by the length words.
- WAIT: blk_valid=1 and in_ready=0; blk_valid is held until blk_done is sampled high.
  - On blk_done with blk_last=0: resume LOAD, or PAD if the marker or the extra block is pending.
  - On blk_done with blk_last=1: clear bitlen and return to IDLE.
- blk_done is ignored outside WAIT.
- in_valid in non-ready states has no effect.
- Length overflow beyond LEN_W wraps modulo 2^LEN_W.
- Latency: last input word to blk_valid equals (16 - slots already filled) + 1 cycles.
- Reset mid-operation aborts the message. No partial blk_valid is issued, and the store contents are left undefined.

Optional Feature:
SHA256_PAD_STATS_EN
- Defined: adds output blk_count[31:0], incremented on every blk_valid&&blk_done and cleared only by reset. Also adds output msg_count[31:0], incremented when the final block is acknowledged.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package sha256_pkg holds:
  - the FSM state encoding (IDLE, LOAD, PAD, LEN_HI, LEN_LO, WAIT);
  - SHA256_BLOCK_WORDS=16, SHA256_LEN_SLOT_HI=14, SHA256_LEN_SLOT_LO=15;
  - the padding marker constant 32'h80000000.
- One sub-module: sha256_pad_marker. It is combinational: (in_data, in_nbytes) -> marked final word. It masks the invalid bytes and inserts 0x80.

Test Plan:
- "abc": in_data 0x61626300, nbytes 3, last -> word0 0x61626380; words 1..14 = 0; word15 0x00000018; blk_valid with blk_last=1.
- Empty message: nbytes 0, last, single beat -> word0 0x80000000; words 1..15 = 0; blk_last=1.
- 56-byte message (14 words, last nbytes 4) -> block 1 has word14 0x80000000, word15 0, blk_last=0. After blk_done, block 2 has words 0..14 = 0, word15 0x000001C0, blk_last=1.
- 64-byte message (16 words) -> block 1 is data only, blk_last=0. Block 2 has word0 0x80000000, words 1..14 = 0, word15 0x00000200.
- Backpressure: blk_done delayed 10 cycles with in_valid held high -> in_ready=0 and no word_we during WAIT; resume at word_addr 0 the cycle after blk_done.
- Reset mid-LOAD after 5 words -> all outputs return to reset values. A following "abc" message produces the exact "abc" block, with bitlen restarting from 0.
